// File: rtl/axi_arb_pkg.sv
// Shared types and AXI defaults for the DDR read/write port arbiters.
// Pure declarations: no latency, no flow control.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  localparam int AXI_ADDR_W = 30;
  localparam int AXI_DATA_W = 256;
  localparam int AXI_ID_W   = 4;
  localparam int AXI_LEN_W  = 4;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_32B   = 3'b101;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: one-hot grant, prio breaks ties (0 = req[0]).
// Latency: combinational; backpressure: none, caller decides when to sample.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = prio ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/axi4_rd_arb2.sv
// Two-client AXI4 read arbiter, one outstanding burst, round-robin per burst.
// Latency: 1 cycle to grant, then zero-latency AR/R pass-through; backpressure: valid/ready forwarded unbuffered.
module axi4_rd_arb2
  import axi_arb_pkg::*;
#(
  parameter int ADDR_W = AXI_ADDR_W,
  parameter int DATA_W = AXI_DATA_W,
  parameter int ID_W   = AXI_ID_W,
  parameter int LEN_W  = AXI_LEN_W
) (
  input  logic              axi_clk,
  input  logic              axi_resetn,
  input  logic [ID_W-1:0]   s0_arid,
  input  logic [ADDR_W-1:0] s0_araddr,
  input  logic [LEN_W-1:0]  s0_arlen,
  input  logic [2:0]        s0_arsize,
  input  logic [1:0]        s0_arburst,
  input  logic              s0_arvalid,
  output logic              s0_arready,
  output logic [ID_W-1:0]   s0_rid,
  output logic [DATA_W-1:0] s0_rdata,
  output logic [1:0]        s0_rresp,
  output logic              s0_rlast,
  output logic              s0_rvalid,
  input  logic              s0_rready,
  input  logic [ID_W-1:0]   s1_arid,
  input  logic [ADDR_W-1:0] s1_araddr,
  input  logic [LEN_W-1:0]  s1_arlen,
  input  logic [2:0]        s1_arsize,
  input  logic [1:0]        s1_arburst,
  input  logic              s1_arvalid,
  output logic              s1_arready,
  output logic [ID_W-1:0]   s1_rid,
  output logic [DATA_W-1:0] s1_rdata,
  output logic [1:0]        s1_rresp,
  output logic              s1_rlast,
  output logic              s1_rvalid,
  input  logic              s1_rready,
  output logic [ID_W-1:0]   m_arid,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [LEN_W-1:0]  m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [ID_W-1:0]   m_rid,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  input  logic              m_rvalid,
  output logic              m_rready,
  output logic [1:0]        grant,
  output logic              len_err
);

  localparam logic [LEN_W:0] CNT_MAX = '1;

  arb_state_t       state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             prio_q, prio_d;
  logic [LEN_W-1:0] exp_len_q, exp_len_d;
  logic [LEN_W:0]   beat_cnt_q, beat_cnt_d;
  logic [1:0]       pick_gnt;
  logic             sel1;

  rr_pick2 u_pick (
    .req  ({s1_arvalid, s0_arvalid}),
    .prio (prio_q),
    .gnt  (pick_gnt)
  );

  assign sel1  = grant_q[1];
  assign grant = grant_q;

  // AR payload follows the registered owner so it stays stable outside ADDR
  assign m_arid    = sel1 ? s1_arid    : s0_arid;
  assign m_araddr  = sel1 ? s1_araddr  : s0_araddr;
  assign m_arlen   = sel1 ? s1_arlen   : s0_arlen;
  assign m_arsize  = sel1 ? s1_arsize  : s0_arsize;
  assign m_arburst = sel1 ? s1_arburst : s0_arburst;

  assign s0_rid   = m_rid;
  assign s0_rdata = m_rdata;
  assign s0_rresp = m_rresp;
  assign s0_rlast = m_rlast;
  assign s1_rid   = m_rid;
  assign s1_rdata = m_rdata;
  assign s1_rresp = m_rresp;
  assign s1_rlast = m_rlast;

  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q    <= IDLE;
      grant_q    <= 2'b00;
      prio_q     <= 1'b0;
      exp_len_q  <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      prio_q     <= prio_d;
      exp_len_q  <= exp_len_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    prio_d     = prio_q;
    exp_len_d  = exp_len_q;
    beat_cnt_d = beat_cnt_q;
    m_arvalid  = 1'b0;
    s0_arready = 1'b0;
    s1_arready = 1'b0;
    s0_rvalid  = 1'b0;
    s1_rvalid  = 1'b0;
    m_rready   = 1'b0;
    len_err    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|pick_gnt) begin
          grant_d = pick_gnt;
          state_d = ADDR;
        end
      end
      ADDR: begin
        m_arvalid  = sel1 ? s1_arvalid : s0_arvalid;
        s0_arready = grant_q[0] & m_arready;
        s1_arready = grant_q[1] & m_arready;
        if (m_arvalid && m_arready) begin
          exp_len_d  = m_arlen;
          beat_cnt_d = '0;
          state_d    = DATA;
        end
      end
      DATA: begin
        s0_rvalid = grant_q[0] & m_rvalid;
        s1_rvalid = grant_q[1] & m_rvalid;
        m_rready  = sel1 ? s1_rready : s0_rready;
        if (m_rvalid && m_rready) begin
          if (beat_cnt_q != CNT_MAX) beat_cnt_d = beat_cnt_q + 1'b1;
          // beat_cnt counts beats before this one, so the last beat must see arlen
          if (m_rlast) begin
            len_err = (beat_cnt_q != {1'b0, exp_len_q});
            state_d = IDLE;
            grant_d = 2'b00;
            prio_d  = ~sel1;
          end else begin
            len_err = (beat_cnt_q == {1'b0, exp_len_q});
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi4_rd_arb2.sv
// Scoreboard bench for axi4_rd_arb2: bench acts as both clients and the DDR port.
module tb_axi4_rd_arb2;
  import axi_arb_pkg::*;

  localparam int AW = 30, DW = 256, IW = 4, LW = 4;

  logic          axi_clk = 1'b0, axi_resetn = 1'b0;
  logic [IW-1:0] s0_arid = '0, s1_arid = '0, m_arid, m_rid = '0, s0_rid, s1_rid;
  logic [AW-1:0] s0_araddr = '0, s1_araddr = '0, m_araddr;
  logic [LW-1:0] s0_arlen = '0, s1_arlen = '0, m_arlen;
  logic [2:0]    s0_arsize = SIZE_32B, s1_arsize = SIZE_32B, m_arsize;
  logic [1:0]    s0_arburst = BURST_INCR, s1_arburst = BURST_INCR, m_arburst;
  logic          s0_arvalid = 0, s1_arvalid = 0, s0_arready, s1_arready;
  logic [DW-1:0] s0_rdata, s1_rdata, m_rdata = '0;
  logic [1:0]    s0_rresp, s1_rresp, m_rresp = '0, grant;
  logic          s0_rlast, s1_rlast, s0_rvalid, s1_rvalid, s0_rready = 1, s1_rready = 1;
  logic          m_arvalid, m_arready = 0, m_rlast = 0, m_rvalid = 0, m_rready, len_err;

  always #5 axi_clk = ~axi_clk;

  axi4_rd_arb2 #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .LEN_W(LW)) dut (
    .axi_clk(axi_clk), .axi_resetn(axi_resetn),
    .s0_arid(s0_arid), .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arsize(s0_arsize),
    .s0_arburst(s0_arburst), .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
    .s0_rid(s0_rid), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rlast(s0_rlast),
    .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
    .s1_arid(s1_arid), .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arsize(s1_arsize),
    .s1_arburst(s1_arburst), .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
    .s1_rid(s1_rid), .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rlast(s1_rlast),
    .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .grant(grant), .len_err(len_err)
  );

  typedef struct {
    int            c;
    logic [IW-1:0] id;
    logic [DW-1:0] d;
    logic          last;
    logic          lerr;
  } exp_beat_t;

  exp_beat_t sb_q[$];
  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // R monitor: every handshake seen by a client pops one expected beat
  always @(negedge axi_clk) begin
    logic hs0, hs1;
    exp_beat_t e;
    hs0 = s0_rvalid & s0_rready;
    hs1 = s1_rvalid & s1_rready;
    if (s0_rvalid && s1_rvalid) chk("rvalid_both", 1'b1, 1'b0);
    if (hs0 || hs1) begin
      if (sb_q.size() == 0) chk("sb_underflow", 1'b1, 1'b0);
      else begin
        e = sb_q.pop_front();
        chk("r_client", hs1 ? 1 : 0, e.c);
        chk("r_data", hs1 ? s1_rdata : s0_rdata, e.d);
        chk("r_id", hs1 ? s1_rid : s0_rid, e.id);
        chk("r_last", hs1 ? s1_rlast : s0_rlast, e.last);
        chk("len_err_beat", len_err, e.lerr);
      end
    end else if (len_err) chk("len_err_nohs", len_err, 1'b0);
  end

  function automatic logic [IW-1:0] cid(input int c);
    return (c == 0) ? 4'h3 : 4'hA;
  endfunction

  task automatic set_ar(input int c, input logic [AW-1:0] a, input logic [LW-1:0] l);
    if (c == 0) begin s0_arvalid = 1; s0_araddr = a; s0_arlen = l; s0_arid = cid(0); end
    else        begin s1_arvalid = 1; s1_araddr = a; s1_arlen = l; s1_arid = cid(1); end
  endtask

  task automatic set_rready(input int c, input logic v);
    if (c == 0) s0_rready = v; else s1_rready = v;
  endtask

  // Wait for grant, check forwarded AR, hold m_arready off for dly cycles, then accept
  task automatic ar_phase(input int c, input logic [AW-1:0] a, input logic [LW-1:0] l, input int dly);
    logic [1:0] g;
    g = (c == 0) ? 2'b01 : 2'b10;
    for (int i = 0; i < 20; i++) begin
      @(negedge axi_clk);
      if (grant == g) break;
    end
    chk("grant", grant, g);
    chk("m_arvalid", m_arvalid, 1'b1);
    chk("m_araddr", m_araddr, a);
    chk("m_arlen", m_arlen, l);
    chk("m_arid", m_arid, cid(c));
    for (int i = 0; i < dly; i++) begin
      chk("arready_wait", {s1_arready, s0_arready}, 2'b00);
      @(posedge axi_clk); #1;
      @(negedge axi_clk);
    end
    @(posedge axi_clk); #1;
    m_arready = 1;
    @(negedge axi_clk);
    chk("arready_fwd", {s1_arready, s0_arready}, g);
    @(posedge axi_clk); #1;
    m_arready = 0;
    if (c == 0) s0_arvalid = 0; else s1_arvalid = 0;
  endtask

  // DDR side: n beats for client c, burst declared with arlen l; bp stalls odd beats once
  task automatic r_beats(input int c, input int l, input int n, input bit bp);
    exp_beat_t e;
    for (int i = 0; i < n; i++) begin
      e.c = c; e.id = cid(c); e.last = (i == n - 1);
      e.d = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
      e.lerr = e.last ? (i != l) : (i == l);
      m_rvalid = 1; m_rdata = e.d; m_rid = e.id; m_rlast = e.last;
      sb_q.push_back(e);
      if (bp && (i % 2 == 1)) begin
        set_rready(c, 0);
        @(negedge axi_clk);
        chk("m_rready_lo", m_rready, 1'b0);
        @(posedge axi_clk); #1;
        set_rready(c, 1);
      end
      @(negedge axi_clk);
      chk("m_rready_hi", m_rready, 1'b1);
      @(posedge axi_clk); #1;
    end
    m_rvalid = 0; m_rlast = 0;
  endtask

  task automatic apply_reset();
    axi_resetn = 0;
    repeat (2) @(posedge axi_clk);
    @(negedge axi_clk);
    chk("rst_outs", {s0_arready, s1_arready, s0_rvalid, s1_rvalid, m_arvalid, m_rready, len_err}, 7'd0);
    chk("rst_grant", grant, 2'b00);
    @(posedge axi_clk); #1;
    axi_resetn = 1;
  endtask

  initial begin
    apply_reset();

    // Single requester with 3-cycle AR stall
    set_ar(0, 30'h1000, 4'd7);
    @(negedge axi_clk);
    chk("arb_lat_grant", grant, 2'b00);
    chk("arb_lat_arvalid", m_arvalid, 1'b0);
    ar_phase(0, 30'h1000, 4'd7, 3);
    r_beats(0, 7, 8, 0);
    @(negedge axi_clk);
    chk("grant_release", grant, 2'b00);

    // Simultaneous requests after reset: s0, then s1, then s0 wins the tie
    apply_reset();
    set_ar(0, 30'h2000, 4'd1);
    set_ar(1, 30'h3000, 4'd2);
    ar_phase(0, 30'h2000, 4'd1, 0);
    r_beats(0, 1, 2, 0);
    @(negedge axi_clk);
    chk("gap_grant", grant, 2'b00);
    @(negedge axi_clk);
    chk("next_grant_s1", grant, 2'b10);
    ar_phase(1, 30'h3000, 4'd2, 0);
    set_ar(0, 30'h4000, 4'd3);
    set_ar(1, 30'h5000, 4'd15);
    r_beats(1, 2, 3, 0);
    ar_phase(0, 30'h4000, 4'd3, 1);
    r_beats(0, 3, 4, 0);

    // Back-pressure on a 16-beat s1 burst
    ar_phase(1, 30'h5000, 4'd15, 0);
    r_beats(1, 15, 16, 1);

    // Short burst: arlen 7, rlast on beat 6
    set_ar(0, 30'h6000, 4'd7);
    ar_phase(0, 30'h6000, 4'd7, 0);
    r_beats(0, 7, 6, 0);

    // Long burst: arlen 3, rlast on beat 6
    set_ar(1, 30'h7000, 4'd3);
    ar_phase(1, 30'h7000, 4'd3, 0);
    r_beats(1, 3, 6, 0);
    @(negedge axi_clk);
    chk("long_idle", grant, 2'b00);

    // Reset mid-burst: outputs must clear without waiting for an edge
    set_ar(0, 30'h8000, 4'd7);
    ar_phase(0, 30'h8000, 4'd7, 0);
    s0_rready = 0;
    m_rvalid = 1; m_rdata = '1; m_rid = cid(0);
    @(negedge axi_clk);
    chk("pre_rst_rvalid", s0_rvalid, 1'b1);
    #2 axi_resetn = 0;
    #1;
    chk("async_rst_outs", {s0_arready, s1_arready, s0_rvalid, s1_rvalid, m_arvalid, m_rready, len_err}, 7'd0);
    chk("async_rst_grant", grant, 2'b00);
    m_rvalid = 0; s0_rready = 1;
    @(posedge axi_clk); #1;
    axi_resetn = 1;

    // Priority back at s0 after reset
    set_ar(0, 30'h9000, 4'd0);
    set_ar(1, 30'hA000, 4'd0);
    ar_phase(0, 30'h9000, 4'd0, 0);
    r_beats(0, 0, 1, 0);
    ar_phase(1, 30'hA000, 4'd0, 0);
    r_beats(1, 0, 1, 0);

    repeat (2) @(negedge axi_clk);
    chk("sb_drain", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
